racetrack_port_arbiter: RTL
===========================

Name: racetrack_port_arbiter

Overview:
Shares one racetrack memory bank (racetrack FSM plus datapath) between the core's data port (port D) and instruction port (port I). Requests are accepted on an OBI-style req/gnt/rvalid handshake and arbitrated round-robin. Exactly one transaction at a time is sequenced into the bank's level-sensitive enable. The block watchdogs bank completion. Logic-in-memory (LiM) operations are permitted on port D only.

Parameters:
ADDR_WIDTH, 22, word address width presented to the bank
DATA_WIDTH, 32, data width of both ports and the bank
TIMEOUT_CYCLES, 256, max BUSY cycles without mem_valid_i before abort (>=2)
CNT_WIDTH, 9, width of watchdog counter; must hold TIMEOUT_CYCLES

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
d_req_i  in  1  port D request
d_gnt_o  out  1  port D grant (combinational)
d_addr_i  in  ADDR_WIDTH  port D address
d_we_i  in  1  port D write enable
d_be_i  in  4  port D byte enables
d_wdata_i  in  DATA_WIDTH  port D write data
d_funct_i  in  8  port D LiM function code
d_rvalid_o  out  1  port D response valid (1-cycle pulse)
d_rdata_o  out  DATA_WIDTH  port D read data
d_err_o  out  1  port D error, qualified by d_rvalid_o
i_req_i  in  1  port I request
i_gnt_o  out  1  port I grant
i_addr_i  in  ADDR_WIDTH  port I address
i_rvalid_o  out  1  port I response valid
i_rdata_o  out  DATA_WIDTH  port I read data
i_err_o  out  1  port I error, qualified by i_rvalid_o
mem_en_o  out  1  bank enable (level)
mem_we_o  out  1  bank write enable
mem_be_o  out  4  bank byte enables
mem_addr_o  out  ADDR_WIDTH  bank address
mem_wdata_o  out  DATA_WIDTH  bank write data
mem_funct_o  out  8  bank LiM function
mem_valid_i  in  1  bank completion pulse (read data valid / write done)
mem_rdata_i  in  DATA_WIDTH  bank read data
busy_o  out  1  arbiter not IDLE

Behaviour:
- Interface is fixed: one clock clk_i; reset rst_i is synchronous and active-high.
- States: IDLE, BUSY, RELEASE.
- Reset values:
  - state=IDLE, rr_ptr=D (D wins the first tie).
  - All outputs are 0, including mem_* payload registers, rdata/err registers, and the watchdog counter.
- Reset asserted mid-transaction returns to IDLE next edge. mem_en_o drops that edge. No rvalid is generated for the aborted transaction.
- IDLE:
  - Winner is the port with req high. If both are high, the winner is rr_ptr.
  - The winner's gnt_o is asserted combinationally in the same cycle; the other gnt_o is 0. gnt_o is never asserted outside IDLE.
  - On the grant edge, latch the payload into mem_* registers and record the owner.
  - Toggle rr_ptr to the non-owner.
  - Load watchdog=TIMEOUT_CYCLES-1 and go to BUSY.
  - Port I payload is forced: we=0, be=4'b1111, wdata=0, funct=0x00 (FUNCT_NONE).
- BUSY:
  - mem_en_o=1. mem_* are held stable for the whole state.
  - On mem_valid_i: register mem_rdata_i into the owner's rdata_o, pulse the owner's rvalid_o for 1 cycle on the next edge with err=0, and go to RELEASE.
  - For writes, rdata_o is the registered mem_rdata_i value and is don't-care to requesters.
  - Otherwise, if watchdog==0: pulse the owner's rvalid_o with err_o=1 and rdata_o=0, then go to RELEASE.
  - Otherwise decrement the watchdog.
  - Latency: grant cycle G; mem_en_o high G+1; valid at V; rvalid at V+1.
- RELEASE:
  - mem_en_o=0 for exactly one cycle, so the bank sees the enable drop before its port-reset completes and does not re-launch.
  - Then go to IDLE. A new grant is possible in the RELEASE+1 cycle, giving a minimum of 3 cycles between grants.
- mem_valid_i outside BUSY is ignored.
- mem_valid_i on the same cycle the watchdog reaches 0: success wins (err=0).
- Requesters must hold req and payload until gnt. A req dropped before gnt is not a violation; no transaction is recorded.
- rvalid_o and err_o of the non-owner stay 0. rdata_o holds its last value between pulses.
- busy_o = (state != IDLE).

Test Plan:
1. Port D read only: d_req=1, addr=0x00010, mem_valid at G+5 with rdata=0xCAFE0001 -> d_gnt at G, mem_en_o high G+1..G+5 (cycle of mem_valid_i), d_rvalid at G+6 with d_rdata=0xCAFE0001, d_err=0, mem_en_o low at G+6 (RELEASE).
2. Simultaneous requests after reset, both held -> grants D, I, D, I in order; each grant is at least 3 cycles after the previous mem_valid_i-completed transaction; no two gnt in the same cycle.
3. Port I request while port D has funct=0x?? (AND code), we=1 -> D transaction drives mem_funct_o=AND, mem_we_o=1; subsequent I transaction drives mem_funct_o=0x00, mem_we_o=0, mem_be_o=4'b1111.
4. Bank never returns valid, TIMEOUT_CYCLES=8 -> owner rvalid with err=1 and rdata=0 exactly 9 cycles after grant; mem_en_o low the following cycle; next request is then served normally.
5. rst_i asserted 2 cycles into BUSY -> next cycle state IDLE, all outputs 0, no rvalid pulse, rr_ptr=D.
6. mem_valid_i in the same cycle the watchdog hits 0 -> rvalid with err=0 and the bank's data; stray mem_valid_i in IDLE -> no rvalid on either port.

Source files
------------

// File: rtl/racetrack_port_arbiter_if.sv
// Bundles the two requester ports (D and I) and the racetrack bank port of
// racetrack_port_arbiter. Signal names keep the arbiter-side direction suffix.
//   slave  : arbiter side (requests/bank responses in, grants/responses/bank cmd out)
//   master : requester + bank side (testbench or core/bank glue)
interface racetrack_port_arbiter_if #(
  parameter int ADDR_WIDTH = 22,
  parameter int DATA_WIDTH = 32
);
  logic                  d_req_i;
  logic                  d_gnt_o;
  logic [ADDR_WIDTH-1:0] d_addr_i;
  logic                  d_we_i;
  logic [3:0]            d_be_i;
  logic [DATA_WIDTH-1:0] d_wdata_i;
  logic [7:0]            d_funct_i;
  logic                  d_rvalid_o;
  logic [DATA_WIDTH-1:0] d_rdata_o;
  logic                  d_err_o;

  logic                  i_req_i;
  logic                  i_gnt_o;
  logic [ADDR_WIDTH-1:0] i_addr_i;
  logic                  i_rvalid_o;
  logic [DATA_WIDTH-1:0] i_rdata_o;
  logic                  i_err_o;

  logic                  mem_en_o;
  logic                  mem_we_o;
  logic [3:0]            mem_be_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [7:0]            mem_funct_o;
  logic                  mem_valid_i;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  logic                  busy_o;

  modport slave (
    input  d_req_i, d_addr_i, d_we_i, d_be_i, d_wdata_i, d_funct_i,
    input  i_req_i, i_addr_i,
    input  mem_valid_i, mem_rdata_i,
    output d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o,
    output i_gnt_o, i_rvalid_o, i_rdata_o, i_err_o,
    output mem_en_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, mem_funct_o,
    output busy_o
  );

  modport master (
    output d_req_i, d_addr_i, d_we_i, d_be_i, d_wdata_i, d_funct_i,
    output i_req_i, i_addr_i,
    output mem_valid_i, mem_rdata_i,
    input  d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o,
    input  i_gnt_o, i_rvalid_o, i_rdata_o, i_err_o,
    input  mem_en_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, mem_funct_o,
    input  busy_o
  );
endinterface

// File: rtl/racetrack_port_arbiter.sv
// Round-robin arbiter sharing one racetrack memory bank between the data
// port (D, may issue LiM functions) and the instruction port (I, reads only).
// One transaction at a time drives the bank's level enable; a watchdog aborts
// a transaction the bank never completes.
// Ports:
//   clk_i  : clock
//   rst_i  : synchronous active-high reset
//   bus    : racetrack_port_arbiter_if.slave (D/I req/gnt/rvalid ports, bank port, busy_o)
module racetrack_port_arbiter #(
  parameter int ADDR_WIDTH     = 22,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_WIDTH      = 9
) (
  input logic                     clk_i,
  input logic                     rst_i,
  racetrack_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RELEASE} state_t;
  typedef enum logic {PORT_D, PORT_I} port_t;

  localparam logic [7:0]           FUNCT_NONE = 8'h00;
  localparam logic [CNT_WIDTH-1:0] WD_LOAD    = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t r_state, w_state_nxt;
  port_t  r_rr_ptr, r_owner;
  logic   w_d_win, w_i_win;

  logic [CNT_WIDTH-1:0]  r_wd;
  logic                  r_mem_we;
  logic [3:0]            r_mem_be;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [7:0]            r_mem_funct;

  logic                  r_d_rvalid, r_d_err, r_i_rvalid, r_i_err;
  logic [DATA_WIDTH-1:0] r_d_rdata, r_i_rdata;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_d_win     = 1'b0;
    w_i_win     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.d_req_i && (!bus.i_req_i || r_rr_ptr == PORT_D)) w_d_win = 1'b1;
        else if (bus.i_req_i)                                    w_i_win = 1'b1;
        if (w_d_win || w_i_win) w_state_nxt = S_BUSY;
      end
      // Completion and watchdog expiry both leave BUSY; the datapath decides
      // which response is produced (completion has priority).
      S_BUSY:    if (bus.mem_valid_i || r_wd == '0) w_state_nxt = S_RELEASE;
      S_RELEASE: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr_ptr    <= PORT_D;
      r_owner     <= PORT_D;
      r_wd        <= '0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_funct <= '0;
      r_d_rvalid  <= 1'b0;
      r_d_err     <= 1'b0;
      r_d_rdata   <= '0;
      r_i_rvalid  <= 1'b0;
      r_i_err     <= 1'b0;
      r_i_rdata   <= '0;
    end else begin
      r_d_rvalid <= 1'b0;
      r_d_err    <= 1'b0;
      r_i_rvalid <= 1'b0;
      r_i_err    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_d_win) begin
            r_owner     <= PORT_D;
            r_rr_ptr    <= PORT_I;
            r_wd        <= WD_LOAD;
            r_mem_we    <= bus.d_we_i;
            r_mem_be    <= bus.d_be_i;
            r_mem_addr  <= bus.d_addr_i;
            r_mem_wdata <= bus.d_wdata_i;
            r_mem_funct <= bus.d_funct_i;
          end else if (w_i_win) begin
            // Instruction fetches are plain full-word reads.
            r_owner     <= PORT_I;
            r_rr_ptr    <= PORT_D;
            r_wd        <= WD_LOAD;
            r_mem_we    <= 1'b0;
            r_mem_be    <= 4'b1111;
            r_mem_addr  <= bus.i_addr_i;
            r_mem_wdata <= '0;
            r_mem_funct <= FUNCT_NONE;
          end
        end
        S_BUSY: begin
          if (bus.mem_valid_i) begin
            if (r_owner == PORT_D) begin
              r_d_rvalid <= 1'b1;
              r_d_rdata  <= bus.mem_rdata_i;
            end else begin
              r_i_rvalid <= 1'b1;
              r_i_rdata  <= bus.mem_rdata_i;
            end
          end else if (r_wd == '0) begin
            if (r_owner == PORT_D) begin
              r_d_rvalid <= 1'b1;
              r_d_err    <= 1'b1;
              r_d_rdata  <= '0;
            end else begin
              r_i_rvalid <= 1'b1;
              r_i_err    <= 1'b1;
              r_i_rdata  <= '0;
            end
          end else begin
            r_wd <= r_wd - CNT_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.d_gnt_o     = w_d_win;
  assign bus.i_gnt_o     = w_i_win;
  assign bus.d_rvalid_o  = r_d_rvalid;
  assign bus.d_rdata_o   = r_d_rdata;
  assign bus.d_err_o     = r_d_err;
  assign bus.i_rvalid_o  = r_i_rvalid;
  assign bus.i_rdata_o   = r_i_rdata;
  assign bus.i_err_o     = r_i_err;
  assign bus.mem_en_o    = (r_state == S_BUSY);
  assign bus.mem_we_o    = r_mem_we;
  assign bus.mem_be_o    = r_mem_be;
  assign bus.mem_addr_o  = r_mem_addr;
  assign bus.mem_wdata_o = r_mem_wdata;
  assign bus.mem_funct_o = r_mem_funct;
  assign bus.busy_o      = (r_state != S_IDLE);

endmodule
